// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: lock-state encoding and pointer sizing.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Keeps a one-bit index legal even if a single-requester build is ever elaborated.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   winner
);

    logic [PTR_W-1:0] idx;

    // Walk from the farthest offset back to ptr so the nearest hit is the last one written.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to MAX_BURST beats.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                            full,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic [ptr_width(NUM_REQ)-1:0]   owner,
    output logic                            locked
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] pick_ptr, pick_winner, sel_winner;
    logic             pick_found, sel_found, accept;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (int'(idx) >= NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .winner (pick_winner)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             lock_hit, lock_lost;

    // A lock whose owner has gone quiet is treated as IDLE right away, searching from owner+1.
    assign lock_hit   = (state_q == ARB_LOCK) && req[owner_q];
    assign lock_lost  = (state_q == ARB_LOCK) && !req[owner_q];
    assign pick_ptr   = lock_lost ? next_idx(owner_q) : ptr_q;
    assign sel_found  = lock_hit | pick_found;
    assign sel_winner = lock_hit ? owner_q : pick_winner;
    assign accept     = rst_n && sel_found && !full;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        if (accept) begin
            if (lock_hit) begin
                if (beat_cnt_q + 1'b1 == CNT_W'(MAX_BURST)) begin
                    state_d    = ARB_IDLE;
                    owner_d    = '0;
                    beat_cnt_d = '0;
                    ptr_d      = next_idx(owner_q);
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end else if (MAX_BURST > 1) begin
                state_d    = ARB_LOCK;
                owner_d    = sel_winner;
                beat_cnt_d = CNT_W'(1);
                ptr_d      = next_idx(sel_winner);
            end else begin
                ptr_d = next_idx(sel_winner);
            end
        end else if (!full && lock_lost) begin
            state_d    = ARB_IDLE;
            owner_d    = '0;
            beat_cnt_d = '0;
            ptr_d      = next_idx(owner_q);
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign owner  = owner_q;
    assign locked = (state_q == ARB_LOCK);
`else
    logic unused_burst;

    assign pick_ptr     = ptr_q;
    assign sel_found    = pick_found;
    assign sel_winner   = pick_winner;
    assign accept       = rst_n && sel_found && !full;
    assign unused_burst = ^MAX_BURST;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = next_idx(sel_winner);
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign owner  = '0;
    assign locked = 1'b0;
`endif

    // Grant, write enable and data all collapse to zero whenever no beat is accepted.
    always_comb begin
        gnt     = '0;
        data_in = '0;
        if (accept) begin
            gnt[sel_winner] = 1'b1;
            data_in         = req_data[sel_winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_en = accept;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed sequences then randomized traffic against a reference model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int EFF_BURST = MB;
`else
    localparam int EFF_BURST = 1;
`endif

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          w_en;
        logic [DW-1:0] data;
        logic          locked;
        logic [1:0]    owner;
    } exp_t;

    logic            wclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            full = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    gnt;
    logic            w_en;
    logic [DW-1:0]   data_in;
    logic [1:0]      owner;
    logic            locked;

    exp_t         exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    logic [N-1:0] last_gnt = '0;
    bit           random_data = 1'b0;

    // Reference state: next priority index, current lock owner (-1 = none), beats taken in the lock.
    int m_prio = 0;
    int m_owner = -1;
    int m_beats = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .w_en     (w_en),
        .data_in  (data_in),
        .owner    (owner),
        .locked   (locked)
    );

    always #5 wclk = ~wclk;

    // Expected outputs for the current cycle, then advance the model past the coming edge.
    task automatic modelStep(input logic rst_v, input logic full_v, input logic [N-1:0] req_v,
                             output exp_t e);
        int start;
        int win;
        e = '0;
        if (!rst_v) begin
            m_prio  = 0;
            m_owner = -1;
            m_beats = 0;
            return;
        end
        e.locked = (m_owner >= 0);
        e.owner  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        win = -1;
        if (m_owner >= 0 && req_v[m_owner]) begin
            win = m_owner;
        end else begin
            start = (m_owner >= 0) ? (m_owner + 1) % N : m_prio;
            for (int k = 0; k < N; k++)
                if (win < 0 && req_v[(start + k) % N]) win = (start + k) % N;
            if (m_owner >= 0 && !full_v) begin
                m_prio  = start;
                m_owner = -1;
                m_beats = 0;
            end
        end
        if (full_v || win < 0) return;
        e.gnt[win] = 1'b1;
        e.w_en     = 1'b1;
        e.data     = req_data[win*DW +: DW];
        if (m_owner == win) begin
            m_beats++;
            if (m_beats == EFF_BURST) begin
                m_owner = -1;
                m_beats = 0;
                m_prio  = (win + 1) % N;
            end
        end else if (EFF_BURST > 1) begin
            m_owner = win;
            m_beats = 1;
        end else begin
            m_prio = (win + 1) % N;
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic full_v, input logic [N-1:0] req_v);
        exp_t e;
        @(negedge wclk);
        if (random_data)
            for (int i = 0; i < N; i++)
                if (!req[i] || last_gnt[i]) req_data[i*DW +: DW] = DW'($urandom);
        rst_n = rst_v;
        full  = full_v;
        req   = req_v;
        modelStep(rst_v, full_v, req_v, e);
        exp_q.push_back(e);
        last_gnt = e.gnt;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("gnt",     32'(gnt),     32'(e.gnt));
        checkField("w_en",    32'(w_en),    32'(e.w_en));
        checkField("data_in", 32'(data_in), 32'(e.data));
        checkField("locked",  32'(locked),  32'(e.locked));
        checkField("owner",   32'(owner),   32'(e.owner));
    endtask

    // Monitor: samples mid-low-phase, after the driver has settled the inputs for this cycle.
    initial begin
        exp_t mon_e;
        forever begin
            @(negedge wclk);
            #3;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] rv;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        applyStimulus(1'b0, 1'b0, 4'b1111);
        repeat (5) applyStimulus(1'b1, 1'b0, 4'b1111);
        repeat (3) applyStimulus(1'b1, 1'b1, 4'b0100);
        applyStimulus(1'b1, 1'b0, 4'b0100);
        repeat (2) applyStimulus(1'b1, 1'b0, 4'b0011);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        repeat (2) applyStimulus(1'b1, 1'b0, 4'b0011);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b0010);
        applyStimulus(1'b1, 1'b0, 4'b1111);
        repeat (2) applyStimulus(1'b1, 1'b1, 4'b1111);
        repeat (4) applyStimulus(1'b1, 1'b0, 4'b1111);
        repeat (2) applyStimulus(1'b1, 1'b0, 4'b1111);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b1111);

        random_data = 1'b1;
        repeat (600) begin
            for (int i = 0; i < N; i++)
                rv[i] = (req[i] && !last_gnt[i] && $urandom_range(0, 3) != 0) ? 1'b1
                                                                               : 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0, rv);
        end

        @(negedge wclk);
        #5;
        checkField("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
